// File: rtl/hw_enc_host_if.sv
// Avalon-MM link between the hw_enc_host master and the hw_imp slave.
// The master drives address/write/writedata/read; the slave answers with
// readdata/waitrequest.
interface hw_enc_host_if #(
  parameter int DATA_W = 32
);
  logic              address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/hw_enc_host.sv
// Avalon-MM master feeding the hw_imp encryption slave.
// One operation: eight data/key writes to the data port, status polling until
// bit 0 is set, then four result reads. Bus strobes are decoded from the state
// so they drop the moment reset is asserted.
module hw_enc_host #(
  parameter int DATA_W        = 32,
  parameter int NUM_IN_WORDS  = 8,
  parameter int NUM_OUT_WORDS = 4,
  parameter int POLL_LIMIT    = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_IN_WORDS/2*DATA_W-1:0] data_in,
  input  logic [NUM_IN_WORDS/2*DATA_W-1:0] key_in,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [NUM_OUT_WORDS*DATA_W-1:0] result,
  hw_enc_host_if.master                   bus
);

  localparam int HALF_W = NUM_IN_WORDS / 2 * DATA_W;
  localparam int IDX_W  = $clog2(NUM_IN_WORDS + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam int WSEL_W = $clog2(NUM_IN_WORDS);
  localparam int RSEL_W = $clog2(NUM_OUT_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    POLL,
    READ,
    DONE,
    ERR
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [POLL_W-1:0]   poll_cnt, poll_cnt_next;
  logic [2*HALF_W-1:0] shadow;
  logic                load_shadow;
  logic                capture;
  logic [DATA_W-1:0]   in_words [NUM_IN_WORDS];

  // Shadow holds data words in the low half and key words in the high half,
  // so write beat n simply sends shadow word n.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN_WORDS; gi++) begin : g_unpack
      assign in_words[gi] = shadow[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State, beat index, poll counter, shadow block and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      poll_cnt <= '0;
      shadow   <= '0;
      result   <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      poll_cnt <= poll_cnt_next;
      if (load_shadow) begin
        shadow <= {key_in, data_in};
      end
      if (capture) begin
        result[idx[RSEL_W-1:0]*DATA_W +: DATA_W] <= bus.readdata;
      end
    end
  end

  // Next-state logic and bus/status decode; a beat advances only when the
  // slave is not stalling, so all strobes and writedata hold during waitrequest.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    poll_cnt_next = poll_cnt;
    load_shadow   = 1'b0;
    capture       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    bus.address   = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.read      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = WRITE;
          idx_next    = '0;
          load_shadow = 1'b1;
        end
      end
      WRITE: begin
        busy          = 1'b1;
        bus.address   = 1'b1;
        bus.write     = 1'b1;
        bus.writedata = in_words[idx[WSEL_W-1:0]];
        if (!bus.waitrequest) begin
          if (idx == IDX_W'(NUM_IN_WORDS - 1)) begin
            state_next    = POLL;
            idx_next      = '0;
            poll_cnt_next = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      POLL: begin
        busy     = 1'b1;
        bus.read = 1'b1;
        if (!bus.waitrequest) begin
          if (bus.readdata[0]) begin
            state_next = READ;
            idx_next   = '0;
          end else begin
            poll_cnt_next = poll_cnt + 1'b1;
            if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
              state_next = ERR;
            end
          end
        end
      end
      READ: begin
        busy        = 1'b1;
        bus.address = 1'b1;
        bus.read    = 1'b1;
        if (!bus.waitrequest) begin
          capture = 1'b1;
          if (idx == IDX_W'(NUM_OUT_WORDS - 1)) begin
            state_next = DONE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hw_enc_host.sv
// Bench for hw_enc_host: two instances (POLL_LIMIT 1024 and 4) share the local
// stimulus; each has its own scripted Avalon slave and a transaction-level
// model (beat counts and expected words) checked on every falling edge.
module tb_hw_enc_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start;
  logic [127:0] data_in, key_in;
  logic         busy0, done0, err0, busy1, done1, err1;
  logic [127:0] result0, result1;

  hw_enc_host_if #(.DATA_W(32)) bus0 ();
  hw_enc_host_if #(.DATA_W(32)) bus1 ();

  hw_enc_host #(.POLL_LIMIT(1024)) dut0 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key_in(key_in),
    .busy(busy0), .done(done0), .err(err0), .result(result0), .bus(bus0)
  );
  hw_enc_host #(.POLL_LIMIT(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key_in(key_in),
    .busy(busy1), .done(done1), .err(err1), .result(result1), .bus(bus1)
  );

  logic        s_w[2], s_r[2], s_a[2], s_busy[2], s_done[2], s_err[2];
  logic [31:0] s_wd[2];
  logic [127:0] s_res[2];
  logic        wreq[2];
  logic [31:0] rdat[2];

  assign s_w[0] = bus0.write;   assign s_w[1] = bus1.write;
  assign s_r[0] = bus0.read;    assign s_r[1] = bus1.read;
  assign s_a[0] = bus0.address; assign s_a[1] = bus1.address;
  assign s_wd[0] = bus0.writedata; assign s_wd[1] = bus1.writedata;
  assign s_busy[0] = busy0; assign s_busy[1] = busy1;
  assign s_done[0] = done0; assign s_done[1] = done1;
  assign s_err[0] = err0;   assign s_err[1] = err1;
  assign s_res[0] = result0; assign s_res[1] = result1;
  assign bus0.waitrequest = wreq[0]; assign bus0.readdata = rdat[0];
  assign bus1.waitrequest = wreq[1]; assign bus1.readdata = rdat[1];

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;

  // slave script
  int          stall_wbeat, stall_rbeat, stall_len, status_zeros;
  bit          never_ready, rand_stall;
  logic [31:0] rd_word [4];

  // model state per instance
  int           limits[2];
  bit           act[2], rdy[2], fin_done[2], fin_err[2];
  int           wb[2], pol[2], rb[2], wsl[2], rsl[2], start_cyc[2];
  logic [255:0] blk[2];
  logic [127:0] exp_res[2];
  // observed activity
  int           dut_lat[2], dcount[2], ecount[2], a_polls[2], a_reads[2];
  int           wd2_cyc;
  logic [31:0]  wlog[$];

  bit          e_w, e_rd, e_a, e_busy, e_done, e_err, idle_now, stall;
  logic [31:0] rnd;

  logic [31:0] exp_wd [8] = '{32'h33221100, 32'h77665544, 32'h10fedcba, 32'h98765432,
                              32'heeff0011, 32'haabbccdd, 32'h9abcdef0, 32'h12345678};

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle compare, slave response and model advance
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i] = 0; rdy[i] = 0; fin_done[i] = 0; fin_err[i] = 0;
        wb[i] = 0; pol[i] = 0; rb[i] = 0;
        exp_res[i] = '0; wreq[i] = 1'b0; rdat[i] = '0;
        chk($sformatf("inst%0d reset write", i), s_w[i], 0);
        chk($sformatf("inst%0d reset read", i), s_r[i], 0);
        chk($sformatf("inst%0d reset busy", i), s_busy[i], 0);
        chk($sformatf("inst%0d reset result", i), s_res[i], 0);
      end else begin
        e_busy = act[i]; e_done = fin_done[i]; e_err = fin_err[i];
        e_w  = act[i] && (wb[i] < 8);
        e_rd = act[i] && (wb[i] == 8);
        e_a  = e_w || (e_rd && rdy[i]);
        chk($sformatf("inst%0d c%0d write", i, cyc), s_w[i], e_w);
        chk($sformatf("inst%0d c%0d read", i, cyc), s_r[i], e_rd);
        chk($sformatf("inst%0d c%0d address", i, cyc), s_a[i], e_a);
        chk($sformatf("inst%0d c%0d busy", i, cyc), s_busy[i], e_busy);
        chk($sformatf("inst%0d c%0d done", i, cyc), s_done[i], e_done);
        chk($sformatf("inst%0d c%0d err", i, cyc), s_err[i], e_err);
        if (e_w) chk($sformatf("inst%0d c%0d writedata", i, cyc), s_wd[i], blk[i][wb[i]*32 +: 32]);
        if (!(act[i] && rdy[i])) chk($sformatf("inst%0d c%0d result", i, cyc), s_res[i], exp_res[i]);
        if (s_done[i]) begin dcount[i]++; dut_lat[i] = cyc - start_cyc[i]; end
        if (s_err[i]) ecount[i]++;
        if (i == 0 && s_w[0] && s_wd[0] == 32'h10fedcba) wd2_cyc++;
        fin_done[i] = 0; fin_err[i] = 0;
        idle_now = !e_busy && !e_done && !e_err;
        rnd = $urandom; wreq[i] = rnd[0]; rdat[i] = $urandom;
        if (e_w) begin
          stall = rand_stall && ($urandom_range(0, 3) == 0);
          if (wb[i] == stall_wbeat && wsl[i] > 0) begin stall = 1'b1; wsl[i]--; end
          wreq[i] = stall;
          if (!stall) begin
            if (i == 0) wlog.push_back(s_wd[0]);
            wb[i]++;
          end
        end else if (e_rd && !rdy[i]) begin
          stall = rand_stall && ($urandom_range(0, 3) == 0);
          wreq[i] = stall;
          if (!stall) begin
            rnd = $urandom;
            rnd[0] = !(never_ready || pol[i] < status_zeros);
            rdat[i] = rnd;
            if (rnd[0]) begin
              rdy[i] = 1; rb[i] = 0;
            end else begin
              pol[i]++;
              if (pol[i] == limits[i]) begin act[i] = 0; fin_err[i] = 1; end
            end
          end
        end else if (e_rd) begin
          stall = rand_stall && ($urandom_range(0, 3) == 0);
          if (rb[i] == stall_rbeat && rsl[i] > 0) begin stall = 1'b1; rsl[i]--; end
          wreq[i] = stall;
          if (!stall) begin
            rdat[i] = rd_word[rb[i]];
            exp_res[i][rb[i]*32 +: 32] = rd_word[rb[i]];
            rb[i]++;
            if (rb[i] == 4) begin act[i] = 0; fin_done[i] = 1; end
          end
        end
        if (s_r[i] && !wreq[i]) begin
          if (s_a[i]) a_reads[i]++; else a_polls[i]++;
        end
        if (start && idle_now) begin
          act[i] = 1; wb[i] = 0; rdy[i] = 0; pol[i] = 0; rb[i] = 0;
          blk[i] = {key_in, data_in}; start_cyc[i] = cyc;
          wsl[i] = stall_len; rsl[i] = stall_len;
          a_polls[i] = 0; a_reads[i] = 0; dut_lat[i] = -1;
          if (i == 0) wlog.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] d, input logic [127:0] k);
    data_in = d; key_in = k; start = 1'b1;
    tick();
    start = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    key_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((act[0] || act[1] || fin_done[0] || fin_done[1] || fin_err[0] || fin_err[1]) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      cmp_n++; err_n++;
      $display("FAIL %s timeout: still busy after %0d cycles, required idle", nm, n);
    end
    tick(); tick();
  endtask

  task automatic set_default();
    stall_wbeat = -1; stall_rbeat = -1; stall_len = 0;
    status_zeros = 0; never_ready = 0; rand_stall = 0;
  endtask

  task automatic chk_wlog(input string nm);
    logic [31:0] got;
    chk({nm, " write count"}, wlog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      got = (k < wlog.size()) ? wlog[k] : 32'hxxxxxxxx;
      chk($sformatf("%s writedata%0d", nm, k), got, exp_wd[k]);
    end
  endtask

  localparam logic [127:0] D  = 128'h98765432_10fedcba_77665544_33221100;
  localparam logic [127:0] K  = 128'h12345678_9abcdef0_aabbccdd_eeff0011;
  localparam logic [127:0] RA = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] RB = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] RC = 128'h000000C3_000000C2_000000C1_000000C0;

  initial begin
    int d0, d1, e0, e1;
    reset = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
    limits[0] = 1024; limits[1] = 4;
    for (int i = 0; i < 2; i++) begin dcount[i] = 0; ecount[i] = 0; dut_lat[i] = -1; end
    wd2_cyc = 0;
    set_default();
    rd_word = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    repeat (3) tick();
    chk("reset busy0", busy0, 0);
    chk("reset writedata0", bus0.writedata, 0);
    chk("reset result0", result0, 0);
    reset = 1'b0;
    tick();

    // basic operation
    pulse_start(D, K);
    wait_idle(100, "basic");
    chk("basic latency inst0", dut_lat[0], 14);
    chk("basic latency inst1", dut_lat[1], 14);
    chk("basic result", result0, RA);
    chk_wlog("basic");

    // stalls on write beat 2 and read beat 1
    stall_wbeat = 2; stall_rbeat = 1; stall_len = 3; wd2_cyc = 0;
    pulse_start(D, K);
    wait_idle(100, "stall");
    chk("stall latency inst0", dut_lat[0], 20);
    chk("stall latency inst1", dut_lat[1], 20);
    chk("stall word2 cycles", wd2_cyc, 4);
    chk("stall result", result0, RA);
    chk_wlog("stall");
    set_default();

    // status polling: five not-ready reads
    status_zeros = 5;
    rd_word = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    d0 = dcount[0]; e1 = ecount[1];
    pulse_start(D, K);
    wait_idle(100, "poll");
    chk("poll status reads inst0", a_polls[0], 6);
    chk("poll data reads inst0", a_reads[0], 4);
    chk("poll done inst0", dcount[0] - d0, 1);
    chk("poll result inst0", result0, RB);
    chk("poll status reads inst1", a_polls[1], 4);
    chk("poll err inst1", ecount[1] - e1, 1);
    chk("poll result kept inst1", result1, RA);

    // timeout: status never ready
    set_default();
    never_ready = 1;
    d0 = dcount[0]; d1 = dcount[1]; e0 = ecount[0]; e1 = ecount[1];
    pulse_start(D, K);
    wait_idle(1200, "timeout");
    chk("timeout status reads inst1", a_polls[1], 4);
    chk("timeout err inst1", ecount[1] - e1, 1);
    chk("timeout no done inst1", dcount[1] - d1, 0);
    chk("timeout result kept inst1", result1, RA);
    chk("timeout busy inst1", busy1, 0);
    chk("timeout status reads inst0", a_polls[0], 1024);
    chk("timeout err inst0", ecount[0] - e0, 1);
    chk("timeout no done inst0", dcount[0] - d0, 0);
    chk("timeout result kept inst0", result0, RB);

    // reset during write beat 5
    set_default();
    rd_word = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    pulse_start(D, K);
    repeat (5) @(posedge clk);
    #1;
    chk("beat5 write", bus0.write, 1);
    chk("beat5 writedata", bus0.writedata, 32'haabbccdd);
    #1 reset = 1'b1;
    #1;
    chk("async reset write0", bus0.write, 0);
    chk("async reset read0", bus0.read, 0);
    chk("async reset busy0", busy0, 0);
    chk("async reset result0", result0, 0);
    chk("async reset write1", bus1.write, 0);
    chk("async reset result1", result1, 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_start(D, K);
    wait_idle(100, "after reset");
    chk_wlog("after reset");
    chk("after reset latency", dut_lat[0], 14);
    chk("after reset result", result0, RA);

    // start during POLL is ignored
    status_zeros = 3;
    rd_word = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    d0 = dcount[0]; d1 = dcount[1];
    pulse_start(D, K);
    repeat (8) tick();
    pulse_start(~D, ~K);
    wait_idle(100, "start while busy");
    chk("busy start done count inst0", dcount[0] - d0, 1);
    chk("busy start done count inst1", dcount[1] - d1, 1);
    chk("busy start status reads", a_polls[0], 4);
    chk("busy start result inst0", result0, RC);
    chk("busy start result inst1", result1, RC);
    chk_wlog("busy start");

    // randomized operations with random stalls and poll delays
    set_default();
    rand_stall = 1;
    for (int t = 0; t < 20; t++) begin
      status_zeros = $urandom_range(0, 6);
      for (int k = 0; k < 4; k++) rd_word[k] = $urandom;
      pulse_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      wait_idle(400, $sformatf("random op %0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
